// File: rtl/lc3_isdu.sv
// lc3_isdu: LC-3 instruction sequencer/decoder (Moore FSM).
// Fetches, decodes and executes ADD/AND/NOT/LDR/STR/BR/JMP and the pause
// handshake. Each memory access state lasts MEM_WAIT cycles.
// Optional feature macro: ISDU_JSR_EN enables JSR/JSRR (states S04/S21/S20);
// without it opcode 0100 decodes as a NOP.
// Outputs are registered and decoded from the next state, so every output
// reflects the current state with no input-to-output combinational path.
module lc3_isdu #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    typedef enum logic [4:0] {
        S_HALT = 5'd0,
        S_18, S_33, S_35, S_32,
        S_01, S_05, S_09,
        S_06, S_25, S_27,
        S_07, S_23, S_16,
        S_00, S_22, S_12,
`ifdef ISDU_JSR_EN
        S_04, S_21, S_20,
`endif
        S_P1, S_P2
    } state_t;

    // Control word; field order matches the port list above.
    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Idle control word: nothing loaded or gated, memory strobes inactive.
    localparam ctrl_t CTRL_IDLE = 24'h000003;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    ctrl_t           ctrl_q, ctrl_d;

`ifndef ISDU_JSR_EN
    logic unused_ir11_s;
    assign unused_ir11_s = IR_11;
`endif

    // Next-state and memory wait counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HALT: begin
                if (Run) state_d = S_18;
                else     state_d = S_HALT;
            end
            S_18: begin
                state_d = S_33;
                cnt_d   = '0;
            end
            S_33, S_25, S_16: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        S_33:    state_d = S_35;
                        S_25:    state_d = S_27;
                        default: state_d = S_18;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_35: state_d = S_32;
            S_32: begin
                case (Opcode)
                    4'b0001: state_d = S_01;
                    4'b0101: state_d = S_05;
                    4'b1001: state_d = S_09;
                    4'b0110: state_d = S_06;
                    4'b0111: state_d = S_07;
                    4'b0000: state_d = S_00;
                    4'b1100: state_d = S_12;
`ifdef ISDU_JSR_EN
                    4'b0100: state_d = S_04;
`endif
                    4'b1101: state_d = S_P1;
                    default: state_d = S_18;
                endcase
            end
            S_06: begin
                state_d = S_25;
                cnt_d   = '0;
            end
            S_07: state_d = S_23;
            S_23: begin
                state_d = S_16;
                cnt_d   = '0;
            end
            S_00: begin
                if (BEN) state_d = S_22;
                else     state_d = S_18;
            end
`ifdef ISDU_JSR_EN
            S_04: begin
                if (IR_11) state_d = S_21;
                else       state_d = S_20;
            end
`endif
            S_P1: begin
                if (Continue) state_d = S_P2;
                else          state_d = S_P1;
            end
            S_P2: begin
                if (!Continue) state_d = S_18;
                else           state_d = S_P2;
            end
            S_01, S_05, S_09, S_27, S_22, S_12: state_d = S_18;
`ifdef ISDU_JSR_EN
            S_21, S_20: state_d = S_18;
`endif
            default: begin
                state_d = S_HALT;
                cnt_d   = '0;
            end
        endcase
    end

    // Control word for the state being entered on the next edge.
    always_comb begin
        ctrl_d = CTRL_IDLE;
        case (state_d)
            S_18: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.ld_mar  = 1'b1;
                ctrl_d.ld_pc   = 1'b1;
            end
            S_33, S_25: begin
                ctrl_d.mem_oe = 1'b0;
                ctrl_d.ld_mdr = (cnt_d == CNT_LAST);
            end
            S_35: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_ir    = 1'b1;
            end
            S_32: ctrl_d.ld_ben = 1'b1;
            S_01, S_05: begin
                ctrl_d.sr2mux   = IR_5;
                ctrl_d.aluk     = (state_d == S_05) ? 2'b01 : 2'b00;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_09: begin
                ctrl_d.aluk     = 2'b10;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_06, S_07: begin
                ctrl_d.addr1mux    = 1'b1;
                ctrl_d.addr2mux    = 2'b01;
                ctrl_d.gate_marmux = 1'b1;
                ctrl_d.ld_mar      = 1'b1;
            end
            S_27: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_23: begin
                ctrl_d.sr1mux   = 1'b1;
                ctrl_d.aluk     = 2'b11;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_mdr   = 1'b1;
            end
            S_16: ctrl_d.mem_we = 1'b0;
            S_22: begin
                ctrl_d.addr2mux = 2'b10;
                ctrl_d.pcmux    = 2'b10;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_12: begin
                ctrl_d.aluk     = 2'b11;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.pcmux    = 2'b01;
                ctrl_d.ld_pc    = 1'b1;
            end
`ifdef ISDU_JSR_EN
            S_04: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.drmux   = 1'b1;
                ctrl_d.ld_reg  = 1'b1;
            end
            S_21: begin
                ctrl_d.addr2mux = 2'b11;
                ctrl_d.pcmux    = 2'b10;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_20: begin
                ctrl_d.addr1mux = 1'b1;
                ctrl_d.pcmux    = 2'b10;
                ctrl_d.ld_pc    = 1'b1;
            end
`endif
            // LED latch fires only on the cycle P1 is entered.
            S_P1: ctrl_d.ld_led = (state_q != S_P1);
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // State, wait counter and registered control outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALT;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;

endmodule

// File: tb/tb_lc3_isdu.sv
// Self-checking bench for lc3_isdu. A MEM_WAIT=2 instance runs a table of
// instructions whose expected per-cycle control words are queued and
// compared each cycle; a MEM_WAIT=3 instance loops STR for timing checks.
module tb_lc3_isdu;

    localparam int MW = 2;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       g_pc, g_mdr, g_alu, g_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mem_oe, mem_we;
    } ov_t;

    typedef enum logic [4:0] {
        ST_NONE, STH, ST18, ST33, ST35, ST32, ST01, ST05, ST09, ST06, ST25, ST27,
        ST07, ST23, ST16, ST00, ST22, ST12, ST04, ST21, ST20, STP1, STP2
    } st_t;

    typedef struct { ov_t v; st_t s; } exp_t;
    typedef struct packed {
        logic [3:0] op;
        logic       i5, i11, bn;
        st_t        e0, e1, e2;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue;
    logic [3:0] op2;
    logic       ir5, ir11, ben;
    wire [23:0] o2, o3;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[13];

    always #5 Clk = ~Clk;

    lc3_isdu #(.MEM_WAIT(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(op2), .IR_5(ir5), .IR_11(ir11), .BEN(ben),
        .LD_MAR(o2[23]), .LD_MDR(o2[22]), .LD_IR(o2[21]), .LD_BEN(o2[20]),
        .LD_CC(o2[19]), .LD_REG(o2[18]), .LD_PC(o2[17]), .LD_LED(o2[16]),
        .GatePC(o2[15]), .GateMDR(o2[14]), .GateALU(o2[13]), .GateMARMUX(o2[12]),
        .PCMUX(o2[11:10]), .DRMUX(o2[9]), .SR1MUX(o2[8]), .SR2MUX(o2[7]),
        .ADDR1MUX(o2[6]), .ADDR2MUX(o2[5:4]), .ALUK(o2[3:2]),
        .Mem_OE(o2[1]), .Mem_WE(o2[0])
    );

    lc3_isdu #(.MEM_WAIT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(4'b0111), .IR_5(1'b0), .IR_11(1'b0), .BEN(1'b0),
        .LD_MAR(o3[23]), .LD_MDR(o3[22]), .LD_IR(o3[21]), .LD_BEN(o3[20]),
        .LD_CC(o3[19]), .LD_REG(o3[18]), .LD_PC(o3[17]), .LD_LED(o3[16]),
        .GatePC(o3[15]), .GateMDR(o3[14]), .GateALU(o3[13]), .GateMARMUX(o3[12]),
        .PCMUX(o3[11:10]), .DRMUX(o3[9]), .SR1MUX(o3[8]), .SR2MUX(o3[7]),
        .ADDR1MUX(o3[6]), .ADDR2MUX(o3[5:4]), .ALUK(o3[3:2]),
        .Mem_OE(o3[1]), .Mem_WE(o3[0])
    );

    // Expected control word for each state, straight from the state table.
    function automatic ov_t exp_out(st_t s, bit last, bit entry, bit i5);
        ov_t r;
        r = '0;
        r.mem_oe = 1'b1;
        r.mem_we = 1'b1;
        case (s)
            ST18: begin r.g_pc = 1'b1; r.ld_mar = 1'b1; r.ld_pc = 1'b1; end
            ST33, ST25: begin r.mem_oe = 1'b0; r.ld_mdr = last; end
            ST35: begin r.g_mdr = 1'b1; r.ld_ir = 1'b1; end
            ST32: r.ld_ben = 1'b1;
            ST01: begin r.sr2mux = i5; r.g_alu = 1'b1; r.ld_reg = 1'b1; r.ld_cc = 1'b1; end
            ST05: begin r.sr2mux = i5; r.aluk = 2'b01; r.g_alu = 1'b1; r.ld_reg = 1'b1; r.ld_cc = 1'b1; end
            ST09: begin r.aluk = 2'b10; r.g_alu = 1'b1; r.ld_reg = 1'b1; r.ld_cc = 1'b1; end
            ST06, ST07: begin r.addr1mux = 1'b1; r.addr2mux = 2'b01; r.g_marmux = 1'b1; r.ld_mar = 1'b1; end
            ST27: begin r.g_mdr = 1'b1; r.ld_reg = 1'b1; r.ld_cc = 1'b1; end
            ST23: begin r.sr1mux = 1'b1; r.aluk = 2'b11; r.g_alu = 1'b1; r.ld_mdr = 1'b1; end
            ST16: r.mem_we = 1'b0;
            ST22: begin r.addr2mux = 2'b10; r.pcmux = 2'b10; r.ld_pc = 1'b1; end
            ST12: begin r.aluk = 2'b11; r.g_alu = 1'b1; r.pcmux = 2'b01; r.ld_pc = 1'b1; end
            ST04: begin r.g_pc = 1'b1; r.drmux = 1'b1; r.ld_reg = 1'b1; end
            ST21: begin r.addr2mux = 2'b11; r.pcmux = 2'b10; r.ld_pc = 1'b1; end
            ST20: begin r.addr1mux = 1'b1; r.pcmux = 2'b10; r.ld_pc = 1'b1; end
            STP1: r.ld_led = entry;
            default: ;
        endcase
        return r;
    endfunction

    task automatic push_one(st_t s, bit last, bit entry, bit i5);
        exp_t e;
        e.v = exp_out(s, last, entry, i5);
        e.s = s;
        q.push_back(e);
    endtask

    task automatic push_st(st_t s, bit i5);
        if (s == ST33 || s == ST25 || s == ST16) begin
            for (int k = 0; k < MW; k++) push_one(s, (k == MW - 1), 1'b0, i5);
        end else if (s != ST_NONE) begin
            push_one(s, 1'b0, 1'b0, i5);
        end
    endtask

    task automatic push_fetch(bit i5);
        push_st(ST18, i5); push_st(ST33, i5); push_st(ST35, i5); push_st(ST32, i5);
    endtask

    // Wait until every queued expectation is consumed; returns just after
    // the following rising edge, so the DUT is already in the next cycle.
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge Clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", q.size());
            q.delete();
        end
    endtask

    // Scoreboard: compare one expected control word per cycle.
    always @(negedge Clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (o2 !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.s.name(), o2, e.v);
            end
        end
    end

    // MEM_WAIT=3 instance: STR loop timing and write-strobe length.
    initial begin : mw3_check
        ov_t a;
        int  first, second, we_len, we_max, s23;
        first = -1; second = -1; we_len = 0; we_max = 0; s23 = 0;
        wait (Run === 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            a = o3;
            if (a.g_pc && a.ld_mar) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (!a.mem_we) we_len++;
            else we_len = 0;
            if (we_len > we_max) we_max = we_len;
            if (a.ld_mdr && a.g_alu && first >= 0 && second < 0) begin
                s23++;
                checks++;
                if (a !== exp_out(ST23, 1'b0, 1'b0, 1'b0)) begin
                    errors++;
                    $display("FAIL mw3_s23: got %h required %h", a, exp_out(ST23, 1'b0, 1'b0, 1'b0));
                end
            end
        end
        checks++;
        if (second - first != 11) begin
            errors++;
            $display("FAIL mw3_str_period: got %0d required 11", second - first);
        end
        checks++;
        if (we_max != 3) begin
            errors++;
            $display("FAIL mw3_we_len: got %0d required 3", we_max);
        end
        checks++;
        if (s23 != 1) begin
            errors++;
            $display("FAIL mw3_s23_count: got %0d required 1", s23);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin : main
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        op2 = 4'b0000; ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;

        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 1'b0, ST01, ST_NONE, ST_NONE};
        tbl[1]  = '{4'b0101, 1'b0, 1'b0, 1'b0, ST05, ST_NONE, ST_NONE};
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 1'b0, ST01, ST_NONE, ST_NONE};
        tbl[3]  = '{4'b1001, 1'b0, 1'b0, 1'b0, ST09, ST_NONE, ST_NONE};
        tbl[4]  = '{4'b0110, 1'b0, 1'b0, 1'b0, ST06, ST25, ST27};
        tbl[5]  = '{4'b0111, 1'b0, 1'b0, 1'b0, ST07, ST23, ST16};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ST00, ST_NONE, ST_NONE};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, ST00, ST22, ST_NONE};
        tbl[8]  = '{4'b1100, 1'b0, 1'b0, 1'b0, ST12, ST_NONE, ST_NONE};
`ifdef ISDU_JSR_EN
        tbl[9]  = '{4'b0100, 1'b0, 1'b1, 1'b0, ST04, ST21, ST_NONE};
        tbl[10] = '{4'b0100, 1'b0, 1'b0, 1'b0, ST04, ST20, ST_NONE};
`else
        tbl[9]  = '{4'b0100, 1'b0, 1'b1, 1'b0, ST_NONE, ST_NONE, ST_NONE};
        tbl[10] = '{4'b0100, 1'b0, 1'b0, 1'b0, ST_NONE, ST_NONE, ST_NONE};
`endif
        tbl[11] = '{4'b1111, 1'b0, 1'b0, 1'b0, ST_NONE, ST_NONE, ST_NONE};
        tbl[12] = '{4'b0010, 1'b1, 1'b0, 1'b1, ST_NONE, ST_NONE, ST_NONE};

        // Reset for three cycles, then idle in Halted with Run low.
        repeat (3) push_st(STH, 1'b0);
        drain();
        Reset = 1'b0;
        push_st(STH, 1'b0);
        push_st(STH, 1'b0);
        drain();
        Run = 1'b1;
        push_st(STH, 1'b0);

        // Instruction table; Run drops after the first one and must not matter.
        for (int i = 0; i < 13; i++) begin
            op2 = tbl[i].op; ir5 = tbl[i].i5; ir11 = tbl[i].i11; ben = tbl[i].bn;
            push_fetch(ir5);
            push_st(tbl[i].e0, ir5);
            push_st(tbl[i].e1, ir5);
            push_st(tbl[i].e2, ir5);
            drain();
            if (i == 0) Run = 1'b0;
        end

        // Pause with Continue low: hold in P1 for 20 cycles, then release.
        op2 = 4'b1101; ir5 = 1'b0;
        push_fetch(1'b0);
        push_one(STP1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 19; k++) push_one(STP1, 1'b0, 1'b0, 1'b0);
        drain();
        Continue = 1'b1;
        push_one(STP1, 1'b0, 1'b0, 1'b0);
        repeat (3) push_st(STP2, 1'b0);
        drain();
        Continue = 1'b0;
        push_st(STP2, 1'b0);
        drain();

        // Pause with Continue already high: P1 lasts one cycle.
        Continue = 1'b1;
        push_fetch(1'b0);
        push_one(STP1, 1'b0, 1'b1, 1'b0);
        repeat (2) push_st(STP2, 1'b0);
        drain();
        Continue = 1'b0;
        push_st(STP2, 1'b0);
        drain();

        // Reset in the middle of a store write cycle.
        op2 = 4'b0111;
        push_fetch(1'b0);
        push_st(ST07, 1'b0);
        push_st(ST23, 1'b0);
        push_one(ST16, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (o2[0] !== 1'b0) begin
            errors++;
            $display("FAIL s16_we_before_reset: got %b required 0", o2[0]);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (o2 !== exp_out(STH, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_s16: got %h required %h", o2, exp_out(STH, 1'b0, 1'b0, 1'b0));
        end
        @(negedge Clk);
        checks++;
        if (o2 !== exp_out(STH, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_held: got %h required %h", o2, exp_out(STH, 1'b0, 1'b0, 1'b0));
        end
        Reset = 1'b0;
        repeat (3) push_st(STH, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
